// File: rtl/ibex_pkg.sv
// Shared FP types for the bfloat16 add/sub writeback path.
package ibex_pkg;

    // FP ALU operator; only ADD and SUB raise status flags in the writeback stage.
    typedef enum logic [1:0] {
        FP_ALU_ADD = 2'd0,
        FP_ALU_SUB = 2'd1,
        FP_ALU_MUL = 2'd2,
        FP_ALU_CMP = 2'd3
    } fp_alu_op_e;

    // IEEE status flags in fflags bit order {NV,DZ,OF,UF,NX}.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_status_t;

    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
    localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;

    // Signalling NaN: all-ones exponent, nonzero mantissa, quiet bit clear.
    function automatic logic bf16_is_snan(input logic [15:0] v);
        return (v[14:7] == BF16_EXP_MAX) && (v[6:0] != 7'd0) && !v[6];
    endfunction

    function automatic logic bf16_is_inf(input logic [15:0] v);
        return (v[14:7] == BF16_EXP_MAX) && (v[6:0] == 7'd0);
    endfunction

    function automatic logic bf16_is_finite(input logic [15:0] v);
        return v[14:7] != BF16_EXP_MAX;
    endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic Depth-entry FIFO with flush; storage and pointers clear on reset.
module fpu_wb_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [Width-1:0]           wdata_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth+1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push in the flush cycle is dropped; Depth is a power of two so pointers wrap naturally.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) begin
                count_d = count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fpu_addsub_wb.sv
// Writeback stage for the bf16 add/sub unit: derives status flags, buffers results toward the
// FP register-file write port and maintains the sticky fflags CSR.
module fpu_addsub_wb
    import ibex_pkg::*;
#(
    parameter int unsigned Depth    = 2,
    parameter int unsigned RegAddrW = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  fp_alu_op_e          in_op_i,
    input  logic [15:0]         in_a_i,
    input  logic [15:0]         in_b_i,
    input  logic [15:0]         in_c_i,
    input  logic [RegAddrW-1:0] in_rd_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [15:0]         out_result_o,
    output logic [RegAddrW-1:0] out_rd_o,
    output logic [4:0]          out_flags_o,
    input  logic                flush_i,
    input  logic                fflags_we_i,
    input  logic [4:0]          fflags_wdata_i,
    output logic [4:0]          fflags_o
);

    localparam int unsigned EntryW = 16 + RegAddrW + 5;
    localparam int unsigned CntW   = $clog2(Depth+1);

    fp_status_t          in_flags;
    logic                eff_sub;
    logic                push, pop;
    logic [EntryW-1:0]   fifo_wdata, fifo_rdata, head;
    logic [CntW-1:0]     fifo_count;
    logic                fifo_full, fifo_empty;
    logic [4:0]          fflags_q, fflags_d;

    // Status flags for the incoming result; non add/sub operators carry no flags.
    always_comb begin
        in_flags = '0;
        eff_sub  = 1'b0;
        if (in_op_i == FP_ALU_ADD || in_op_i == FP_ALU_SUB) begin
            // Inf - Inf in effect: ADD of opposite signs or SUB of equal signs.
            eff_sub     = (in_op_i == FP_ALU_SUB) ? (in_a_i[15] == in_b_i[15])
                                                  : (in_a_i[15] != in_b_i[15]);
            in_flags.nv = bf16_is_snan(in_a_i) | bf16_is_snan(in_b_i) |
                          (bf16_is_inf(in_a_i) & bf16_is_inf(in_b_i) & eff_sub);
            in_flags.dz = 1'b0;
            in_flags.of = bf16_is_finite(in_a_i) & bf16_is_finite(in_b_i) &
                          (in_c_i[14:7] == BF16_EXP_MAX);
            in_flags.uf = (in_c_i[14:7] == 8'h00) && (in_c_i[6:0] != 7'd0);
            in_flags.nx = in_flags.of | in_flags.uf;
        end
    end

    assign push       = in_valid_i & in_ready_o;
    assign pop        = out_valid_o & out_ready_i;
    assign fifo_wdata = {in_c_i, in_rd_i, in_flags};

    fpu_wb_fifo #(
        .Width (EntryW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Ready depends only on occupancy, never on out_ready_i.
    assign in_ready_o  = ~fifo_full;
    assign out_valid_o = (fifo_count != '0);

    // Outputs are held at zero while nothing is buffered.
    assign head = fifo_empty ? '0 : fifo_rdata;
    assign {out_result_o, out_rd_o, out_flags_o} = head;

    // Sticky flags accumulate only on pop; a CSR write replaces the old value first.
    always_comb begin
        fflags_d = fflags_we_i ? fflags_wdata_i : fflags_q;
        if (pop) fflags_d = fflags_d | out_flags_o;
    end

    // fflags CSR register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fpu_addsub_wb.sv
// Scoreboard bench for fpu_addsub_wb: directed scenarios plus a short random phase.
module tb_fpu_addsub_wb;
    import ibex_pkg::*;

    typedef struct packed {
        logic [15:0] res;
        logic [4:0]  rd;
        logic [4:0]  flags;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    fp_alu_op_e  in_op = FP_ALU_ADD;
    logic [15:0] in_a = '0, in_b = '0, in_c = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [4:0]  out_rd, out_flags;
    logic        flush = 1'b0;
    logic        fflags_we = 1'b0;
    logic [4:0]  fflags_wdata = '0;
    logic [4:0]  fflags;

    logic [4:0]  exp_flags_drv = '0;
    sb_t         sb_q[$];
    logic [4:0]  fflags_model = '0;
    int          n_checks = 0;
    int          n_fails = 0;

    always #5 clk = ~clk;

    fpu_addsub_wb #(
        .Depth    (2),
        .RegAddrW (5)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_op_i        (in_op),
        .in_a_i         (in_a),
        .in_b_i         (in_b),
        .in_c_i         (in_c),
        .in_rd_i        (in_rd),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_result_o   (out_result),
        .out_rd_o       (out_rd),
        .out_flags_o    (out_flags),
        .flush_i        (flush),
        .fflags_we_i    (fflags_we),
        .fflags_wdata_i (fflags_wdata),
        .fflags_o       (fflags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference flags model used for random stimulus.
    function automatic logic [4:0] model_flags(input fp_alu_op_e op,
                                               input logic [15:0] a, b, c);
        logic sn_a, sn_b, inf_a, inf_b, fin_a, fin_b, nv, of, uf;
        if (op != FP_ALU_ADD && op != FP_ALU_SUB) return 5'b00000;
        sn_a  = (a[14:7] == 8'hFF) && (a[6:0] != 0) && (a[6] == 1'b0);
        sn_b  = (b[14:7] == 8'hFF) && (b[6:0] != 0) && (b[6] == 1'b0);
        inf_a = (a[14:0] == 15'h7F80);
        inf_b = (b[14:0] == 15'h7F80);
        fin_a = (a[14:7] != 8'hFF);
        fin_b = (b[14:7] != 8'hFF);
        nv    = sn_a | sn_b | (inf_a & inf_b & ((op == FP_ALU_SUB) ^ (a[15] ^ b[15])));
        of    = fin_a & fin_b & (c[14:7] == 8'hFF);
        uf    = (c[14:7] == 8'h00) & (c[6:0] != 0);
        return {nv, 1'b0, of, uf, of | uf};
    endfunction

    // Monitor: compares against the scoreboard once per cycle, between active edges.
    always @(negedge clk) begin
        sb_t exp_e;
        int  occ;
        logic do_pop;
        if (!rst_n) begin
            sb_q.delete();
            fflags_model = '0;
        end else begin
            occ = sb_q.size();
            check("in_ready", 32'(in_ready), 32'(occ < 2));
            check("out_valid", 32'(out_valid), 32'(occ != 0));
            check("fflags", 32'(fflags), 32'(fflags_model));
            if (occ == 0) check("idle_out", {6'd0, out_result, out_rd, out_flags}, 32'd0);
            do_pop = out_valid && out_ready && occ != 0;
            exp_e = '0;
            if (do_pop) begin
                exp_e = sb_q.pop_front();
                check("result", 32'(out_result), 32'(exp_e.res));
                check("rd", 32'(out_rd), 32'(exp_e.rd));
                check("flags", 32'(out_flags), 32'(exp_e.flags));
            end
            fflags_model = (fflags_we ? fflags_wdata : fflags_model) |
                           (do_pop ? exp_e.flags : 5'd0);
            if (in_valid && occ < 2 && !flush) sb_q.push_back('{in_c, in_rd, exp_flags_drv});
            if (flush) sb_q.delete();
        end
    end

    task automatic push_one(input fp_alu_op_e op, input logic [15:0] a, b, c,
                            input logic [4:0] rd, input logic [4:0] ef, input bit rnd_rdy);
        bit acc = 1'b0;
        int tries = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_c = c; in_rd = rd;
        exp_flags_drv = ef;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk); #1;
            tries++;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!acc) check("push_timeout", 32'd0, 32'd1);
        // Garbage on the data inputs while idle must be ignored.
        in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
        in_c = 16'($urandom); in_rd = 5'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    logic [15:0] specials [8];

    initial begin
        specials = '{16'h7F80, 16'hFF80, 16'h7F81, 16'h7FC0,
                     16'h3F80, 16'h7F7F, 16'h0001, 16'h0000};
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fflags", 32'(fflags), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: plain add
        out_ready = 1'b1;
        push_one(FP_ALU_ADD, 16'h3F80, 16'h3F80, 16'h4000, 5'd3, 5'b00000, 1'b0);
        @(posedge clk); #1;
        check("t1_fflags", 32'(fflags), 32'd0);

        // 2: invalid cases
        push_one(FP_ALU_SUB, 16'h7F80, 16'h7F80, 16'h7FC0, 5'd4, 5'b10000, 1'b0);
        push_one(FP_ALU_ADD, 16'h7F81, 16'h3F80, 16'h7FC0, 5'd5, 5'b10000, 1'b0);
        push_one(FP_ALU_ADD, 16'hFF80, 16'h7F80, 16'h7FC0, 5'd6, 5'b10000, 1'b0);
        drain();
        check("t2_fflags", 32'(fflags), 32'b10000);

        // 3: overflow, and Inf operand that does not overflow
        push_one(FP_ALU_ADD, 16'h7F7F, 16'h7F7F, 16'h7F80, 5'd7, 5'b00101, 1'b0);
        push_one(FP_ALU_ADD, 16'h7F80, 16'h3F80, 16'h7F80, 5'd8, 5'b00000, 1'b0);
        push_one(FP_ALU_ADD, 16'h0001, 16'h8000, 16'h0001, 5'd9, 5'b00011, 1'b0);
        push_one(FP_ALU_MUL, 16'h7F81, 16'h7F7F, 16'h0001, 5'd10, 5'b00000, 1'b0);
        drain();
        check("t3_fflags", 32'(fflags), 32'b10111);

        // 4: backpressure with three back-to-back pushes
        out_ready = 1'b0;
        fork
            begin
                push_one(FP_ALU_ADD, 16'h3F80, 16'h4000, 16'h4040, 5'd11, 5'b00000, 1'b0);
                push_one(FP_ALU_SUB, 16'h4000, 16'h3F80, 16'h3F80, 5'd12, 5'b00000, 1'b0);
                push_one(FP_ALU_ADD, 16'h4040, 16'h3F80, 16'h4080, 5'd13, 5'b00000, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // 5: CSR write racing a pop, then flush with a concurrent push
        fflags_we = 1'b1; fflags_wdata = 5'b00101;
        @(posedge clk); #1;
        fflags_we = 1'b0;
        check("t5_wr_fflags", 32'(fflags), 32'b00101);
        out_ready = 1'b0;
        push_one(FP_ALU_SUB, 16'h7F80, 16'h7F80, 16'h7FC0, 5'd14, 5'b10000, 1'b0);
        out_ready = 1'b1; fflags_we = 1'b1; fflags_wdata = 5'b00000;
        @(posedge clk); #1;
        out_ready = 1'b0; fflags_we = 1'b0;
        check("t5_we_pop", 32'(fflags), 32'b10000);
        push_one(FP_ALU_ADD, 16'h7F7F, 16'h7F7F, 16'h7F80, 5'd15, 5'b00101, 1'b0);
        push_one(FP_ALU_ADD, 16'h3F80, 16'h3F80, 16'h4000, 5'd16, 5'b00000, 1'b0);
        in_valid = 1'b1; in_op = FP_ALU_ADD; in_a = 16'h7F81; in_b = 16'h0; in_c = 16'h1;
        in_rd = 5'd17; exp_flags_drv = 5'b10011; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_fflags", 32'(fflags), 32'b10000);
        @(posedge clk); #1;

        // 6: asynchronous reset with two entries buffered
        push_one(FP_ALU_ADD, 16'h0001, 16'h0000, 16'h0001, 5'd18, 5'b00011, 1'b0);
        push_one(FP_ALU_ADD, 16'h3F80, 16'h3F80, 16'h4000, 5'd19, 5'b00000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_fflags", 32'(fflags), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_one(FP_ALU_SUB, 16'h7F80, 16'hFF80, 16'h7F80, 5'd20, 5'b00000, 1'b0);
        drain();

        // Random phase with random output backpressure.
        for (int i = 0; i < 60; i++) begin
            fp_alu_op_e op;
            logic [15:0] a, b, c;
            op = fp_alu_op_e'($urandom_range(0, 3));
            a  = specials[$urandom_range(0, 7)] ^ {$urandom_range(0, 1) == 1, 15'd0};
            b  = specials[$urandom_range(0, 7)] ^ {$urandom_range(0, 1) == 1, 15'd0};
            c  = ($urandom_range(0, 1) == 1) ? specials[$urandom_range(0, 7)] : 16'($urandom);
            push_one(op, a, b, c, 5'($urandom), model_flags(op, a, b, c), 1'b1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
